// File: rtl/instr_register_reader_if.sv
// ---------------------------------------------------------------------------
// instr_register_reader_if
//
// Result stream between the instruction register reader and the result
// checker / scoreboard. One beat is transferred on every rising clock edge
// where result_valid and result_ready are both high.
//
// Parameters:
//   ADDR_W  width of the entry address carried with each beat
//   OPND_W  operand width; the result is 2*OPND_W bits
//
// Signals:
//   result_valid   producer -> consumer  beat available
//   result_ready   consumer -> producer  beat accepted
//   result         producer -> consumer  signed result, 2*OPND_W bits
//   result_opcode  producer -> consumer  opcode of the beat
//   result_addr    producer -> consumer  entry address of the beat
//   result_err     producer -> consumer  illegal opcode or divide/modulo by zero
//
// Modports:
//   master  the reader (drives the beat, samples ready)
//   slave   the consumer (samples the beat, drives ready)
// ---------------------------------------------------------------------------
interface instr_register_reader_if #(
   parameter int ADDR_W = 5,
   parameter int OPND_W = 32
);

   logic                       result_valid;
   logic                       result_ready;
   logic signed [2*OPND_W-1:0] result;
   logic [3:0]                 result_opcode;
   logic [ADDR_W-1:0]          result_addr;
   logic                       result_err;

   modport master (
      output result_valid,
      output result,
      output result_opcode,
      output result_addr,
      output result_err,
      input  result_ready
   );

   modport slave (
      input  result_valid,
      input  result,
      input  result_opcode,
      input  result_addr,
      input  result_err,
      output result_ready
   );

endinterface

// File: rtl/instr_register_reader.sv
// ---------------------------------------------------------------------------
// instr_register_reader
//
// Read-side engine for the instruction register. On an accepted start it
// walks read_pointer from start_addr through instr_count consecutive entries
// (wrapping modulo 2**ADDR_W), captures each instruction word, evaluates its
// opcode on the two signed operands and presents the result as one beat on
// the result stream. A one-cycle done pulse closes each sequence.
//
// Parameters:
//   ADDR_W  width of read_pointer (depth = 2**ADDR_W entries)
//   CNT_W   width of instr_count
//   OPND_W  signed operand width; result is 2*OPND_W bits
//
// Ports:
//   clk               clock, rising edge
//   reset             synchronous active-high reset
//   start             one-cycle request to begin a read sequence
//   start_addr        first entry to read
//   instr_count       number of entries to read (0 is legal)
//   busy              high from the accepted start through the done pulse
//   read_pointer      address into the instruction register
//   instruction_word  {opcode[3:0], operand_a, operand_b}, combinational read
//   done              one-cycle pulse at the end of a sequence
//   stat_beats        (optional) saturating count of accepted beats
//   stat_errs         (optional) saturating count of accepted error beats
//   res               result stream, master side
//
// Optional feature macro: INSTR_READER_STATS_EN adds stat_beats / stat_errs.
// ---------------------------------------------------------------------------
module instr_register_reader #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 6,
   parameter int OPND_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       start_addr,
   input  logic [CNT_W-1:0]        instr_count,
   output logic                    busy,
   output logic [ADDR_W-1:0]       read_pointer,
   input  logic [4+2*OPND_W-1:0]   instruction_word,
   output logic                    done,
`ifdef INSTR_READER_STATS_EN
   output logic [15:0]             stat_beats,
   output logic [15:0]             stat_errs,
`endif
   instr_register_reader_if.master res
);

   localparam int RES_W  = 2 * OPND_W;
   localparam int WORD_W = 4 + RES_W;

   localparam logic [3:0] OP_ZERO  = 4'd0;
   localparam logic [3:0] OP_PASSA = 4'd1;
   localparam logic [3:0] OP_PASSB = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_MULT  = 4'd5;
   localparam logic [3:0] OP_DIV   = 4'd6;
   localparam logic [3:0] OP_MOD   = 4'd7;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      OUT,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic [WORD_W-1:0]       word_q;
   logic [CNT_W-1:0]        remaining;
   logic signed [RES_W-1:0] result_q;
   logic [3:0]              opcode_q;
   logic [ADDR_W-1:0]       addr_q;
   logic                    err_q;

   logic                    transfer;
   logic [3:0]              word_opcode;
   logic signed [RES_W-1:0] a_ext;
   logic signed [RES_W-1:0] b_ext;
   logic signed [RES_W-1:0] exec_result;
   logic                    exec_err;

   // A beat leaves the block only while we are presenting it and the
   // consumer takes it on the same edge.
   assign transfer = (state == OUT) && res.result_ready;

   // Split the captured word and sign-extend both operands to the full result
   // width so every arithmetic op below is done at 2*OPND_W bits; that gives
   // the complete MULT product and keeps the most-negative / -1 DIV case exact.
   assign word_opcode = word_q[WORD_W-1 -: 4];
   assign a_ext = {{OPND_W{word_q[RES_W-1]}}, word_q[RES_W-1 -: OPND_W]};
   assign b_ext = {{OPND_W{word_q[OPND_W-1]}}, word_q[OPND_W-1:0]};

   // State register. Reset from any state drops straight back to IDLE, which
   // is how an in-flight sequence is aborted without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Sequencing and the state-decoded outputs. Starts are only honoured in
   // IDLE, so a start while busy (including the DONE cycle) is simply
   // dropped. A zero count skips directly to DONE so the requester still gets
   // its done pulse. In OUT we only move on once the beat is accepted, and we
   // leave for DONE when the beat being accepted is the last one.
   always_comb begin
      next_state       = state;
      busy             = 1'b1;
      done             = 1'b0;
      res.result_valid = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               next_state = (instr_count == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            next_state = EXEC;
         end
         EXEC: begin
            next_state = OUT;
         end
         OUT: begin
            res.result_valid = 1'b1;
            if (transfer) begin
               next_state = (remaining == CNT_W'(1)) ? DONE : FETCH;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Opcode evaluation on the registered word. Anything outside 0..7, and a
   // DIV or MOD with a zero divisor, reports an error beat with a zero result
   // so the checker never sees an undefined value. SV signed division already
   // truncates toward zero and its remainder takes the sign of the dividend.
   always_comb begin
      exec_result = '0;
      exec_err    = 1'b0;
      case (word_opcode)
         OP_ZERO:  exec_result = '0;
         OP_PASSA: exec_result = a_ext;
         OP_PASSB: exec_result = b_ext;
         OP_ADD:   exec_result = a_ext + b_ext;
         OP_SUB:   exec_result = a_ext - b_ext;
         OP_MULT:  exec_result = a_ext * b_ext;
         OP_DIV: begin
            if (b_ext == '0) begin
               exec_err = 1'b1;
            end else begin
               exec_result = a_ext / b_ext;
            end
         end
         OP_MOD: begin
            if (b_ext == '0) begin
               exec_err = 1'b1;
            end else begin
               exec_result = a_ext % b_ext;
            end
         end
         default: begin
            exec_err = 1'b1;
         end
      endcase
   end

   // Datapath registers. The start address and count are latched only on an
   // accepted start. The word is captured at the end of FETCH, when
   // read_pointer has been stable for a full cycle. The beat fields are loaded
   // once in EXEC and left alone through OUT, which is what keeps them stable
   // under backpressure. The pointer advances (and wraps naturally at the
   // address width) only when a beat is actually accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_pointer <= '0;
         remaining    <= '0;
         word_q       <= '0;
         result_q     <= '0;
         opcode_q     <= '0;
         addr_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  read_pointer <= start_addr;
                  remaining    <= instr_count;
               end
            end
            FETCH: begin
               word_q <= instruction_word;
            end
            EXEC: begin
               result_q <= exec_result;
               err_q    <= exec_err;
               opcode_q <= word_opcode;
               addr_q   <= read_pointer;
            end
            OUT: begin
               if (transfer) begin
                  remaining    <= remaining - CNT_W'(1);
                  read_pointer <= read_pointer + ADDR_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign res.result        = result_q;
   assign res.result_opcode = opcode_q;
   assign res.result_addr   = addr_q;
   assign res.result_err    = err_q;

`ifdef INSTR_READER_STATS_EN
   // Lifetime beat statistics. They survive new starts so a long test can
   // read totals at the end, and they stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_beats <= '0;
         stat_errs  <= '0;
      end else if (transfer) begin
         if (stat_beats != 16'hFFFF) begin
            stat_beats <= stat_beats + 16'd1;
         end
         if (err_q && (stat_errs != 16'hFFFF)) begin
            stat_errs <= stat_errs + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/instr_register_reader.md
Name: instr_register_reader

Overview:
- Read-side engine for the instruction register.
- Given a start pulse, a start address and an instruction count, it:
  - walks `read_pointer` through consecutive entries (with wrap-around),
  - captures each `instruction_word`,
  - evaluates the opcode on the two signed operands,
  - presents each result on a valid/ready output stream.
- Sits between the instruction register's read port and the result checker / scoreboard.

Parameters:
- ADDR_W, 5, width of `read_pointer`. Depth = 2**ADDR_W entries.
- CNT_W, 6, width of the instruction count. Must hold up to 2**ADDR_W.
- OPND_W, 32, signed operand width. The result is 2*OPND_W bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a read sequence.
- start_addr  in  ADDR_W  first entry to read.
- instr_count  in  CNT_W  number of entries to read (0 is legal).
- busy  out  1  high from the accepted start until the done pulse, inclusive.
- read_pointer  out  ADDR_W  address to the instruction register.
- instruction_word  in  4+2*OPND_W  layout:
  - [67:64] opcode
  - [63:32] operand_a
  - [31:0] operand_b
  - the register's read is combinational.
- result_valid  out  1  result beat available.
- result_ready  in  1  downstream accepts the beat.
- result  out  2*OPND_W  signed result.
- result_opcode  out  4  opcode of the current beat.
- result_addr  out  ADDR_W  entry address of the current beat.
- result_err  out  1  beat is an illegal opcode or a divide/modulo by zero.
- done  out  1  one-cycle pulse after the last beat is accepted (or for count 0).

Behaviour:
- Reset values: state=IDLE; `busy`, `result_valid`, `done`, `result_err` = 0; `read_pointer`, `result`, `result_opcode`, `result_addr` = 0.
- Reset asserted in any state aborts the sequence; the next cycle shows reset values. No `done` pulse is produced for an aborted sequence.
- States: IDLE, FETCH, EXEC, OUT, DONE.
- IDLE:
  - `start`=1 latches `start_addr` into `read_pointer` and `instr_count` into a remaining counter, sets `busy`.
  - Next state is FETCH, or DONE if count=0.
- FETCH: `read_pointer` is stable; `instruction_word` is registered at the end of this cycle. Go to EXEC.
- EXEC: compute the result from the registered word. Go to OUT.
- Opcode semantics (operands signed, sign-extended to 2*OPND_W):
  - 0 ZERO → 0
  - 1 PASSA → a
  - 2 PASSB → b
  - 3 ADD → a+b
  - 4 SUB → a−b
  - 5 MULT → a*b (full-width signed product)
  - 6 DIV → a/b (truncate toward zero)
  - 7 MOD → a%b (sign of a)
- Error cases:
  - Opcodes 8–15 → `result`=0, `result_err`=1.
  - DIV or MOD with b=0 → `result`=0, `result_err`=1.
- OUT:
  - `result_valid`=1 with `result`, `result_opcode`, `result_addr` (= `read_pointer`) and `result_err`.
  - All four fields are held stable while `result_ready`=0.
- Transfer happens on a cycle with `result_valid` & `result_ready`:
  - Decrement the remaining counter.
  - Increment `read_pointer` modulo 2**ADDR_W (depth−1 wraps to 0).
  - If the remaining counter becomes 0, go to DONE; else go to FETCH.
  - `result_valid` drops the cycle after the transfer.
- DONE: `done`=1 for exactly one cycle, `busy` drops the following cycle, return to IDLE.
- `start` while `busy`=1 is ignored; its `start_addr` and `instr_count` are not latched.
- `start` in the same cycle that DONE exits to IDLE is ignored. A new start is accepted only in IDLE.
- Throughput: 3 cycles per instruction with `result_ready` held high.
- Latency from start to first `result_valid`: 3 cycles (FETCH, EXEC, OUT).
- `instr_count` greater than the depth is legal. Reading continues past the wrap and re-reads entries.

Optional Feature:
- INSTR_READER_STATS_EN defined:
  - Adds output `stat_beats` (16 bits): counts accepted result beats.
  - Adds output `stat_errs` (16 bits): counts accepted beats with `result_err`=1.
  - Both counters saturate at 16'hFFFF, are cleared by reset, and are not cleared by `start`.
- Undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Basic ADD: preload entry 2 = {ADD, 5, −3}; start with `start_addr`=2, `instr_count`=1, `result_ready`=1.
  → `result_valid` in cycle 3, `result`=2, `result_addr`=2, `result_err`=0; `done` one cycle after the transfer.
- Wrap-around: preload entries 30, 31, 0 with PASSA 10, 11, 12; start with `start_addr`=30, `instr_count`=3.
  → beats carry `result_addr` 30, 31, 0 and `result` 10, 11, 12; a single `done` pulse.
- Backpressure: hold `result_ready`=0 for 5 cycles on a MULT {−4, 7} beat.
  → `result`=−28 held stable with `result_valid`=1 for all 5 cycles; exactly one transfer when `result_ready` rises.
- Errors: entry opcode 6 with b=0, then opcode 12.
  → both beats `result`=0, `result_err`=1; with INSTR_READER_STATS_EN defined, `stat_errs`=2 and `stat_beats`=2.
- Count zero / start while busy: start with `instr_count`=0.
  → no `result_valid`; `done` 1 cycle after start. Issue a second start mid-sequence → ignored; beat count is unchanged.
- Reset mid-operation: assert `reset` while in OUT.
  → next cycle `busy`=0, `result_valid`=0, `read_pointer`=0, no `done`; a fresh start then behaves normally.
